// File: rtl/noc_pkg.sv
// Shared NoC router definitions: output-port directions, input-port FSM encoding and
// a width helper for counters and port indices.
package noc_pkg;

  localparam int unsigned NORTH = 0;
  localparam int unsigned SOUTH = 1;
  localparam int unsigned WEST  = 2;
  localparam int unsigned EAST  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FWD  = 2'd2,
    REL  = 2'd3
  } state_e;

  // Bits needed to index n values; never less than one so degenerate ranges still synthesize.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/noc_phit_fifo.sv
// Phit buffer for one router input: power-of-two depth, no write-through when full,
// head presented combinationally (zero while empty).
module noc_phit_fifo
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [CNT_W-1:0]      o_count,
  output logic [DATA_WIDTH-1:0] o_head
);

  localparam int unsigned PTR_W = clog2_min1(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_wr;
  logic                  w_rd;

  assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  assign w_wr = i_push & ~o_full;
  assign w_rd = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr && !w_rd) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_wr && w_rd) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/noc_input_port_ctrl.sv
// Router input-port controller: buffers phits, requests the crossbar path named by the
// head flit, streams the wormhole packet through and releases the path after the tail.
module noc_input_port_ctrl
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned PHIT_PER_FLIT   = 2,
  parameter int unsigned FLIT_PER_PACKET = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned N_PORTS         = 4,
  localparam int unsigned PORT_W         = clog2_min1(N_PORTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_req_valid,
  output logic [PORT_W-1:0]     o_req_port,
  input  logic                  i_grant,
  output logic                  o_release,
  output logic                  o_busy
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PHIT_W = clog2_min1(PHIT_PER_FLIT);
  localparam int unsigned FLIT_W = clog2_min1(FLIT_PER_PACKET);

  state_e                r_state;
  state_e                w_state_d;
  logic [PORT_W-1:0]     r_req_port;
  logic [PHIT_W-1:0]     r_phit_cnt;
  logic [FLIT_W-1:0]     r_flit_cnt;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last_phit;
  logic                  w_last_flit;

  assign o_in_ready  = ~w_full;
  assign o_out_data  = w_head;
  assign o_req_port  = r_req_port;
  assign w_push      = i_in_valid & ~w_full;
  assign w_pop       = o_out_valid & i_out_ready;
  assign w_last_phit = (r_phit_cnt == PHIT_W'(PHIT_PER_FLIT - 1));
  assign w_last_flit = (r_flit_cnt == FLIT_W'(FLIT_PER_PACKET - 1));

  noc_phit_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data (i_in_data),
    .i_pop  (w_pop),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(w_count),
    .o_head (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (w_count != '0) w_state_d = REQ;
      REQ:     if (i_grant) w_state_d = FWD;
      FWD:     if (w_pop && w_last_phit && w_last_flit) w_state_d = REL;
      REL:     w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    o_req_valid = 1'b0;
    o_out_valid = 1'b0;
    o_release   = 1'b0;
    o_busy      = (r_state != IDLE);
    unique case (r_state)
      REQ:     o_req_valid = 1'b1;
      FWD:     o_out_valid = ~w_empty;
      REL:     o_release   = 1'b1;
      default: ;
    endcase
  end

  // The FIFO head in IDLE is always phit 0 of a head flit, so its low bits name the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_port <= '0;
    end else if (r_state == IDLE && w_count != '0) begin
      r_req_port <= w_head[PORT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || r_state == REL) begin
      r_phit_cnt <= '0;
      r_flit_cnt <= '0;
    end else if (w_pop) begin
      if (w_last_phit) begin
        r_phit_cnt <= '0;
        r_flit_cnt <= w_last_flit ? '0 : r_flit_cnt + FLIT_W'(1);
      end else begin
        r_phit_cnt <= r_phit_cnt + PHIT_W'(1);
      end
    end
  end

endmodule

// File: doc/noc_input_port_ctrl.md
Name: noc_input_port_ctrl

Overview:
- Per-input-port controller for the mesh NoC router, successor to the single-FSM handshake controller.
- Buffers incoming phits in a parametrised FIFO and decodes the destination port from the head flit.
- Requests and holds a crossbar path from the switch allocator, then streams the whole wormhole packet through.
- Releases the path after the tail phit. One instance per router input; a router instantiates N_PORTS of them.

Parameters:
DATA_WIDTH, 8, phit width in bits
PHIT_PER_FLIT, 2, phits per flit
FLIT_PER_PACKET, 4, flits per packet, head included (HBBT); packet = PKT_PHITS = PHIT_PER_FLIT*FLIT_PER_PACKET phits
FIFO_DEPTH, 4, phit buffer entries; power of two, >= 2
N_PORTS, 4, router output ports (0 N, 1 S, 2 W, 3 E; extra ports local); PORT_W = $clog2(N_PORTS)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream phit valid
in_ready  out  1  upstream may transfer; in_ready = ~full
in_data  in  DATA_WIDTH  upstream phit
out_valid  out  1  phit to crossbar valid
out_ready  in  1  downstream accepts phit
out_data  out  DATA_WIDTH  phit to crossbar (FIFO head)
req_valid  out  1  route request to switch allocator
req_port  out  PORT_W  requested output port
grant  in  1  allocator grants req_port to this input
release  out  1  one-cycle pulse, path free
busy  out  1  state != IDLE

Behaviour:
- Reset: clears FIFO pointers and count, all counters, state = IDLE. in_ready=1, out_valid=0, req_valid=0, release=0, busy=0, out_data=0.
- A reset mid-packet discards buffered phits. No release pulse is generated.
- Handshakes: a transfer occurs on a cycle where valid & ready are both 1.
  - Upstream may assert in_valid without waiting for in_ready.
  - A transfer writes in_data into the FIFO at the tail.
- FIFO:
  - count range 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
  - When full, in_ready=0 even if a pop occurs that cycle (no write-through).
  - Push and pop in the same cycle leave count unchanged.
  - Never push when full; never pop when empty.
- out_data is the FIFO head, combinational from storage. Pop only on out_valid & out_ready.
- FSM states:
  - IDLE: if FIFO non-empty (head phit = phit 0 of head flit) -> REQ, latching req_port = head[PORT_W-1:0]. Nothing is popped.
  - REQ: req_valid=1, req_port held stable. If grant -> FWD, else stay.
  - FWD: out_valid = ~empty. Each pop increments phit_cnt (0..PHIT_PER_FLIT-1). phit_cnt wraps to 0 and increments flit_cnt (0..FLIT_PER_PACKET-1).
    - Pop of the last phit (flit_cnt=FLIT_PER_PACKET-1, phit_cnt=PHIT_PER_FLIT-1) -> REL.
    - An empty FIFO mid-packet: out_valid=0, stay in FWD.
  - REL: release=1 for exactly one cycle; counters cleared; out_valid=0 -> IDLE.
- Latency:
  - Phit accepted at cycle t on an empty IDLE port -> req_valid=1 at t+2 (t+1 FIFO visible/IDLE decode, t+2 REQ).
  - Grant at cycle g -> first out_valid at g+1.
  - Next packet's REQ no earlier than 2 cycles after the tail pop.
- grant outside REQ is ignored. Upstream may keep pushing phits of the next packet during FWD/REL.
- Counter widths: $clog2 of range, minimum 1 bit. PHIT_PER_FLIT=1 and FLIT_PER_PACKET=1 must work.

Decomposition:
- Shared package noc_pkg holds:
  - direction constants NORTH=0, SOUTH=1, WEST=2, EAST=3
  - state encoding IDLE/REQ/FWD/REL (2 bits)
  - PORT_W helper
- One sub-module: noc_phit_fifo (DATA_WIDTH, FIFO_DEPTH; push/pop/full/empty/count/head).
- FSM and counters stay in the top module.

Test Plan:
- Single packet, defaults, out_ready=1, grant asserted when req_valid seen:
  - Send 8 phits, head = 8'h02.
  - req_valid with req_port=2 two cycles after the first push.
  - 8 pops in order, release pulse once, then busy=0.
- Backpressure: out_ready=0 in FWD, push 5 phits.
  - in_ready drops after 4 (full), phit 5 is held upstream.
  - Raise out_ready: all 8 phits are delivered in order with no loss or duplicate.
- Delayed grant: hold grant=0 for 10 cycles.
  - req_valid=1 and req_port stable throughout; out_valid=0.
  - Grant -> out_valid next cycle.
- Back-to-back packets, head ports 3 then 0:
  - Second req_port=0 issued only after the first release.
  - Phits of the second packet buffered during the first's FWD are not forwarded early.
- Bubbles: upstream gaps mid-packet.
  - out_valid=0 while empty, FSM stays in FWD, packet is completed when phits arrive.
- Reset mid-FWD after 3 pops:
  - Next cycle: FIFO empty, in_ready=1, busy=0, no release.
  - A fresh packet afterwards routes correctly. Repeat with PHIT_PER_FLIT=1, FLIT_PER_PACKET=1, FIFO_DEPTH=2.
